vliw_fwd_ctrl: RTL and testbench

- Parametrised forwarding and hazard controller for an N-lane STARBUG VLIW integer pipeline.
- Tracks each lane's destination register and write/late-result tags through the E, M and W stages.
- For every lane, produces separate operand-A and operand-B forward-stage selects plus source-lane indices, which drive each datapath's result-select and forward muxes.
- Also detects load-use / late-result hazards across lanes and illegal same-bundle write-after-write bundles.

---
 rtl/vliw_fwd_ctrl_if.sv | 25 ++
 rtl/vliw_fwd_ctrl.sv | 130 +++++++++++++
 tb/tb_vliw_fwd_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vliw_fwd_ctrl_if.sv
// Forwarding-controller bundle: pipeline controls and per-lane D tags in, forward selects and hazard flags out.
// master drives the D-stage tags and stage controls; slave is the controller itself.
interface vliw_fwd_ctrl_if #(
  parameter int NLANES = 4,
  parameter int LANEW  = $clog2(NLANES)
);
  logic                    StallE, FlushE, StallM, FlushM, StallW, FlushW;
  logic [NLANES*5-1:0]     Rs1D, Rs2D, RdD;
  logic [NLANES-1:0]       RegWriteD, LateResultD;
  logic [NLANES*2-1:0]     ForwardAE, ForwardBE;
  logic [NLANES*LANEW-1:0] FwdLaneAE, FwdLaneBE;
  logic                    HazardStallD, IllegalBundleD;

  modport master (
    output StallE, FlushE, StallM, FlushM, StallW, FlushW,
    output Rs1D, Rs2D, RdD, RegWriteD, LateResultD,
    input  ForwardAE, ForwardBE, FwdLaneAE, FwdLaneBE, HazardStallD, IllegalBundleD
  );

  modport slave (
    input  StallE, FlushE, StallM, FlushM, StallW, FlushW,
    input  Rs1D, Rs2D, RdD, RegWriteD, LateResultD,
    output ForwardAE, ForwardBE, FwdLaneAE, FwdLaneBE, HazardStallD, IllegalBundleD
  );
endinterface

// File: rtl/vliw_fwd_ctrl.sv
// N-lane VLIW forward/hazard controller: E/M/W tag pipeline, outputs combinational from registered tags (0 added latency).
// No backpressure of its own: follows the shared per-stage stall/flush inputs and only requests a D stall on late-result hazards.
module vliw_fwd_ctrl #(
  parameter int NLANES = 4,
  parameter int LANEW  = $clog2(NLANES)
) (
  input  logic           clk,
  input  logic           reset,
  vliw_fwd_ctrl_if.slave bus
);

  logic [NLANES-1:0][4:0] rs1_d, rs2_d, rd_d;
  logic [NLANES-1:0][4:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [NLANES-1:0]      we_e, late_e, we_m, we_w;

  assign rs1_d = bus.Rs1D;
  assign rs2_d = bus.Rs2D;
  assign rd_d  = bus.RdD;

  // Flush wins over stall; a flush clears only the valid bits, addresses are held.
  // The late-result tag is not carried past E: nothing downstream of E consumes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_e  <= '0;
      rs2_e  <= '0;
      rd_e   <= '0;
      we_e   <= '0;
      late_e <= '0;
      rd_m   <= '0;
      we_m   <= '0;
      rd_w   <= '0;
      we_w   <= '0;
    end else begin
      if (bus.FlushE) begin
        we_e   <= '0;
        late_e <= '0;
      end else if (!bus.StallE) begin
        rs1_e  <= rs1_d;
        rs2_e  <= rs2_d;
        rd_e   <= rd_d;
        we_e   <= bus.RegWriteD;
        late_e <= bus.LateResultD;
      end

      if (bus.FlushM) begin
        we_m <= '0;
      end else if (!bus.StallM) begin
        rd_m <= rd_e;
        we_m <= we_e;
      end

      if (bus.FlushW) begin
        we_w <= '0;
      end else if (!bus.StallW) begin
        rd_w <= rd_m;
        we_w <= we_m;
      end
    end
  end

  // Ascending scan so the highest matching lane (youngest in program order) wins.
  function automatic logic [LANEW+1:0] fwd_pick(input logic [4:0] src);
    logic             m_hit;
    logic             w_hit;
    logic [LANEW-1:0] m_lane;
    logic [LANEW-1:0] w_lane;
    m_hit  = 1'b0;
    w_hit  = 1'b0;
    m_lane = '0;
    w_lane = '0;
    for (int j = 0; j < NLANES; j++) begin
      if (src != 5'd0 && we_m[j] && rd_m[j] == src) begin
        m_hit  = 1'b1;
        m_lane = LANEW'(j);
      end
      if (src != 5'd0 && we_w[j] && rd_w[j] == src) begin
        w_hit  = 1'b1;
        w_lane = LANEW'(j);
      end
    end
    if (m_hit)      return {2'b10, m_lane};
    else if (w_hit) return {2'b01, w_lane};
    else            return '0;
  endfunction

  logic [NLANES-1:0][1:0]       fwd_a_sel, fwd_b_sel;
  logic [NLANES-1:0][LANEW-1:0] fwd_a_lane, fwd_b_lane;
  logic                         hazard;
  logic                         illegal;

  always_comb begin
    fwd_a_sel  = '0;
    fwd_b_sel  = '0;
    fwd_a_lane = '0;
    fwd_b_lane = '0;
    for (int i = 0; i < NLANES; i++) begin
      {fwd_a_sel[i], fwd_a_lane[i]} = fwd_pick(rs1_e[i]);
      {fwd_b_sel[i], fwd_b_lane[i]} = fwd_pick(rs2_e[i]);
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int j = 0; j < NLANES; j++) begin
      for (int i = 0; i < NLANES; i++) begin
        if (we_e[j] && late_e[j] && rd_e[j] != 5'd0 &&
            (rd_e[j] == rs1_d[i] || rd_e[j] == rs2_d[i]))
          hazard = 1'b1;
      end
    end
  end

  always_comb begin
    illegal = 1'b0;
    for (int p = 0; p < NLANES; p++) begin
      for (int q = p + 1; q < NLANES; q++) begin
        if (bus.RegWriteD[p] && bus.RegWriteD[q] && rd_d[p] == rd_d[q] && rd_d[p] != 5'd0)
          illegal = 1'b1;
      end
    end
  end

  assign bus.ForwardAE      = fwd_a_sel;
  assign bus.ForwardBE      = fwd_b_sel;
  assign bus.FwdLaneAE      = fwd_a_lane;
  assign bus.FwdLaneBE      = fwd_b_lane;
  assign bus.HazardStallD   = hazard;
  assign bus.IllegalBundleD = illegal;

endmodule

// File: tb/tb_vliw_fwd_ctrl.sv
// Directed scenarios for vliw_fwd_ctrl; expected outputs are queued with the stimulus and retired against the DUT.
module tb_vliw_fwd_ctrl;
  localparam int NLANES = 4;
  localparam int LANEW  = 2;

  // Output selectors used by the scoreboard entries.
  localparam int K_SELA = 0, K_SELB = 1, K_LANEA = 2, K_LANEB = 3, K_HAZ = 4, K_ILL = 5;

  typedef struct {
    string tag;
    int    kind;
    int    lane;
    int    val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  vliw_fwd_ctrl_if #(.NLANES(NLANES), .LANEW(LANEW)) bus ();

  vliw_fwd_ctrl #(.NLANES(NLANES), .LANEW(LANEW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int observe(input int kind, input int lane);
    case (kind)
      K_SELA:  return int'(bus.ForwardAE[2*lane +: 2]);
      K_SELB:  return int'(bus.ForwardBE[2*lane +: 2]);
      K_LANEA: return int'(bus.FwdLaneAE[LANEW*lane +: LANEW]);
      K_LANEB: return int'(bus.FwdLaneBE[LANEW*lane +: LANEW]);
      K_HAZ:   return int'(bus.HazardStallD);
      default: return int'(bus.IllegalBundleD);
    endcase
  endfunction

  task automatic expect_v(input string tag, input int kind, input int lane, input int val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.lane = lane;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.kind, e.lane), e.val);
    end
  endtask

  task automatic clear_d();
    bus.Rs1D        = '0;
    bus.Rs2D        = '0;
    bus.RdD         = '0;
    bus.RegWriteD   = '0;
    bus.LateResultD = '0;
  endtask

  task automatic clear_ctl();
    bus.StallE = 1'b0; bus.FlushE = 1'b0;
    bus.StallM = 1'b0; bus.FlushM = 1'b0;
    bus.StallW = 1'b0; bus.FlushW = 1'b0;
  endtask

  task automatic set_d(input int lane, input int rs1, input int rs2, input int rd,
                       input int we, input int late);
    bus.Rs1D[5*lane +: 5]    = 5'(rs1);
    bus.Rs2D[5*lane +: 5]    = 5'(rs2);
    bus.RdD[5*lane +: 5]     = 5'(rd);
    bus.RegWriteD[lane]      = 1'(we);
    bus.LateResultD[lane]    = 1'(late);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_pipe();
    clear_d();
    clear_ctl();
    repeat (3) step();
  endtask

  initial begin
    reset = 1'b1;
    clear_d();
    clear_ctl();
    #1;
    for (int i = 0; i < NLANES; i++) begin
      expect_v("rst_sela", K_SELA, i, 0);
      expect_v("rst_selb", K_SELB, i, 0);
      expect_v("rst_lanea", K_LANEA, i, 0);
      expect_v("rst_laneb", K_LANEB, i, 0);
    end
    expect_v("rst_haz", K_HAZ, 0, 0);
    expect_v("rst_ill", K_ILL, 0, 0);
    drain();
    #11 reset = 1'b0;
    step();

    // Lane 2 writes x5, lane 0 consumes it from M one bundle later.
    set_d(2, 0, 0, 5, 1, 0);
    step();
    clear_d();
    set_d(0, 5, 6, 0, 0, 0);
    step();
    clear_d();
    expect_v("m_fwd_sela", K_SELA, 0, 2);
    expect_v("m_fwd_lanea", K_LANEA, 0, 2);
    expect_v("m_fwd_selb", K_SELB, 0, 0);
    drain();
    flush_pipe();

    // Lanes 1 and 3 both write x7; lane 2 reads it from W.
    set_d(1, 0, 0, 7, 1, 0);
    set_d(3, 0, 0, 7, 1, 0);
    #1;
    expect_v("waw_ill", K_ILL, 0, 1);
    drain();
    step();
    clear_d();
    step();
    set_d(2, 0, 7, 0, 0, 0);
    step();
    clear_d();
    expect_v("w_fwd_selb", K_SELB, 2, 1);
    expect_v("w_fwd_laneb", K_LANEB, 2, 3);
    expect_v("w_fwd_sela", K_SELA, 2, 0);
    drain();
    flush_pipe();

    // Same, with lane 0 also writing x7 one bundle later: M beats W.
    set_d(1, 0, 0, 7, 1, 0);
    set_d(3, 0, 0, 7, 1, 0);
    step();
    clear_d();
    set_d(0, 0, 0, 7, 1, 0);
    step();
    clear_d();
    set_d(2, 0, 7, 0, 0, 0);
    step();
    clear_d();
    expect_v("mw_fwd_selb", K_SELB, 2, 2);
    expect_v("mw_fwd_laneb", K_LANEB, 2, 0);
    drain();
    flush_pipe();

    // Load-use: lane 0 LW x9, lane 3 reads x9; bench acts as the hazard unit.
    set_d(0, 0, 0, 9, 1, 1);
    step();
    clear_d();
    set_d(3, 0, 9, 0, 0, 0);
    #1;
    expect_v("lu_haz_on", K_HAZ, 0, 1);
    drain();
    bus.FlushE = 1'b1;
    bus.StallE = 1'b1;
    step();
    bus.FlushE = 1'b0;
    bus.StallE = 1'b0;
    expect_v("lu_haz_off", K_HAZ, 0, 0);
    drain();
    step();
    clear_d();
    expect_v("lu_fwd_selb", K_SELB, 3, 1);
    expect_v("lu_fwd_laneb", K_LANEB, 3, 0);
    drain();
    flush_pipe();

    // Every lane writes x0 with a late result; x0 is never forwarded nor a hazard.
    for (int i = 0; i < NLANES; i++) set_d(i, 0, 0, 0, 1, 1);
    #1;
    expect_v("x0_ill", K_ILL, 0, 0);
    drain();
    step();
    clear_d();
    #1;
    expect_v("x0_haz", K_HAZ, 0, 0);
    drain();
    step();
    for (int i = 0; i < NLANES; i++) begin
      expect_v("x0_sela", K_SELA, i, 0);
      expect_v("x0_selb", K_SELB, i, 0);
    end
    drain();
    flush_pipe();

    // Producer held in M by StallM (W bubbled), then squashed by FlushM under stall.
    set_d(1, 0, 0, 12, 1, 0);
    step();
    clear_d();
    set_d(2, 12, 0, 0, 0, 0);
    step();
    clear_d();
    expect_v("stm_sela0", K_SELA, 2, 2);
    expect_v("stm_lanea0", K_LANEA, 2, 1);
    drain();
    bus.StallE = 1'b1;
    bus.StallM = 1'b1;
    bus.FlushW = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      expect_v("stm_sela", K_SELA, 2, 2);
      expect_v("stm_lanea", K_LANEA, 2, 1);
      drain();
    end
    bus.FlushM = 1'b1;
    step();
    bus.FlushM = 1'b0;
    expect_v("flm_sela", K_SELA, 2, 0);
    expect_v("flm_lanea", K_LANEA, 2, 0);
    drain();
    flush_pipe();

    // Asynchronous reset while a forward is active.
    set_d(3, 0, 0, 20, 1, 0);
    step();
    clear_d();
    set_d(1, 20, 20, 0, 0, 0);
    step();
    clear_d();
    expect_v("pre_rst_sela", K_SELA, 1, 2);
    expect_v("pre_rst_laneb", K_LANEB, 1, 3);
    drain();
    #2 reset = 1'b1;
    #1;
    expect_v("arst_sela", K_SELA, 1, 0);
    expect_v("arst_selb", K_SELB, 1, 0);
    expect_v("arst_lanea", K_LANEA, 1, 0);
    expect_v("arst_laneb", K_LANEB, 1, 0);
    expect_v("arst_haz", K_HAZ, 0, 0);
    drain();
    reset = 1'b0;
    step();

    // Same-bundle WAW detection, and the non-writing counterpart.
    set_d(0, 0, 0, 4, 1, 0);
    set_d(1, 0, 0, 4, 1, 0);
    #1;
    expect_v("ill_x4", K_ILL, 0, 1);
    drain();
    bus.RegWriteD[1] = 1'b0;
    #1;
    expect_v("ill_x4_nowe", K_ILL, 0, 0);
    drain();
    clear_d();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
